// File: rtl/instr_prefetch_queue_pkg.sv
// Shared front-end constants: default fetch geometry, reset vector and the
// opcode field encoding that decode uses on the instruction stream.
package instr_prefetch_queue_pkg;

  localparam int              CPU_PC_W        = 8;
  localparam int              CPU_INSTR_W     = 16;
  localparam int              CPU_QUEUE_DEPTH = 4;
  localparam logic [7:0]      CPU_RESET_PC    = 8'h00;

  // Opcode lives in instruction[15:12].
  localparam int              OPCODE_MSB      = 15;
  localparam int              OPCODE_LSB      = 12;

  typedef enum logic [3:0] {
    OP_ALU    = 4'h0,
    OP_ALUI   = 4'h1,
    OP_LOAD   = 4'h2,
    OP_STORE  = 4'h3,
    OP_BRANCH = 4'h4,
    OP_JUMP   = 4'h5,
    OP_NOP    = 4'hF
  } opcode_e;

endpackage

// File: rtl/instr_prefetch_queue_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instruction} pairs.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write din at the tail
//   pop        : drop the head (caller guarantees non-empty)
//   flush      : empty the FIFO; wins over push and pop
//   head       : entry at the read pointer (meaningful when count != 0)
//   count      : occupied entries, 0..DEPTH
module instr_prefetch_queue_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch front end: generates the fetch PC, issues one-cycle
// latency instruction-memory reads and buffers {pc, instruction} pairs for
// decode. A redirect flushes the queue and any read in flight and restarts
// fetch at redirect_pc.
//   clk, reset   : clock, asynchronous active-high reset
//   imem_req     : read strobe, imem_addr = current fetch PC
//   imem_rdata   : read data, valid the cycle after imem_req
//   redirect     : flush + restart at redirect_pc (taken branch / jump)
//   deq_ready    : decode consumes the head this cycle
//   valid        : head entry present; instruction/pc_out are 0 otherwise
//   count        : entries stored in the queue (read in flight excluded)
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int              DEPTH    = CPU_QUEUE_DEPTH,
  parameter int              PC_W     = CPU_PC_W,
  parameter int              INSTR_W  = CPU_INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      imem_req,
  output logic [PC_W-1:0]           imem_addr,
  input  logic [INSTR_W-1:0]        imem_rdata,
  input  logic                      redirect,
  input  logic [PC_W-1:0]           redirect_pc,
  input  logic                      deq_ready,
  output logic                      valid,
  output logic [INSTR_W-1:0]        instruction,
  output logic [PC_W-1:0]           pc_out,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = PC_W + INSTR_W;

  logic [PC_W-1:0]    fetch_pc_p0;
  logic               vld_p1;
  logic [PC_W-1:0]    pc_p1;

  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [CNT_W-1:0]   reserved;
  logic [ENTRY_W-1:0] head_entry;
  logic               take;

  // Stage p0: fetch PC and issue. A slot is reserved for every read in
  // flight, so the queue can never overflow when the response lands.
  assign reserved  = fifo_count + CNT_W'(vld_p1);
  assign imem_req  = !reset && !redirect && (reserved < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
    end else if (redirect) begin
      fetch_pc_p0 <= redirect_pc;
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= imem_req;
      if (imem_req) fetch_pc_p0 <= fetch_pc_p0 + PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_req) pc_p1 <= fetch_pc_p0;
  end

  // Stage p1: response. With the queue empty the returning word is shown
  // directly as the head so a redirect target reaches decode two cycles
  // after the redirect. The head is not gated by redirect: decode derives
  // redirect from the head, so the branch itself is consumed in cycle N.
  assign fifo_empty = (fifo_count == '0);
  assign head_entry = fifo_empty ? {pc_p1, imem_rdata} : fifo_head;
  assign valid      = !fifo_empty || vld_p1;
  assign take       = valid && deq_ready;
  assign fifo_pop   = take && !fifo_empty;
  assign fifo_push  = vld_p1 && !(take && fifo_empty);

  instr_prefetch_queue_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_instr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   ({pc_p1, imem_rdata}),
    .head  (fifo_head),
    .count (fifo_count)
  );

  assign instruction = valid ? head_entry[INSTR_W-1:0] : '0;
  assign pc_out      = valid ? head_entry[ENTRY_W-1:INSTR_W] : '0;
  assign count       = fifo_count;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
`timescale 1ns/1ps
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        deq_ready;
  logic        valid;
  logic [15:0] instruction;
  logic [7:0]  pc_out;
  logic [2:0]  count;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: stored entries as a queue, plus the one read that may be in flight.
  logic [23:0] mq[$];
  bit          minfl;
  logic [7:0]  mipc;
  logic [7:0]  mfpc;

  always #5 clk = ~clk;

  instr_prefetch_queue dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .deq_ready   (deq_ready),
    .valid       (valid),
    .instruction (instruction),
    .pc_out      (pc_out),
    .count       (count)
  );

  function automatic logic [15:0] rom(input logic [7:0] a);
    return {8'hA5, a};
  endfunction

  // Instruction memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) imem_rdata <= imem_req ? rom(imem_addr) : 16'h0BAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    bit          ev;
    bit          ereq;
    logic [23:0] eh;
    if (reset) begin
      ev = 0; ereq = 0; eh = '0;
      chk("addr_rst", 32'(imem_addr), 32'h00);
    end else begin
      ev   = (mq.size() > 0) || minfl;
      eh   = (mq.size() > 0) ? mq[0] : {mipc, rom(mipc)};
      ereq = !redirect && ((mq.size() + int'(minfl)) < 4);
      chk("addr", 32'(imem_addr), 32'(mfpc));
    end
    chk("valid", 32'(valid), 32'(ev));
    chk("instr", 32'(instruction), ev ? 32'(eh[15:0]) : 32'h0);
    chk("pc_out", 32'(pc_out), ev ? 32'(eh[23:16]) : 32'h0);
    chk("count", 32'(count), reset ? 32'h0 : 32'(mq.size()));
    chk("req", 32'(imem_req), 32'(ereq));
  endtask

  task automatic model_reset();
    mq.delete();
    minfl = 0;
    mipc  = 8'h00;
    mfpc  = 8'h00;
  endtask

  // One clock edge of the specification's rules: response joins the tail,
  // an accepted head leaves the front, then a new read is issued if a slot
  // is free. A redirect discards everything and reloads the fetch PC.
  task automatic model_step();
    bit ev;
    bit ereq;
    if (reset) begin
      model_reset();
    end else begin
      ev   = (mq.size() > 0) || minfl;
      ereq = !redirect && ((mq.size() + int'(minfl)) < 4);
      if (redirect) begin
        mq.delete();
        minfl = 0;
        mfpc  = redirect_pc;
      end else begin
        if (minfl) mq.push_back({mipc, rom(mipc)});
        if (ev && deq_ready) void'(mq.pop_front());
        if (ereq) begin
          minfl = 1;
          mipc  = mfpc;
          mfpc  = mfpc + 8'h01;
        end else begin
          minfl = 0;
        end
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic to_pos();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cycle();
    at_neg();
    to_pos();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; redirect_pc = 8'h00; deq_ready = 1'b0;
    model_reset();
    run(2);
    at_neg();
    chk("lit_rst_valid", 32'(valid), 32'h0);
    chk("lit_rst_count", 32'(count), 32'h0);
    chk("lit_rst_req", 32'(imem_req), 32'h0);
    to_pos();

    // 1: free-running fetch from RESET_PC
    reset = 1'b0; deq_ready = 1'b1;
    at_neg();
    chk("lit_c1_req", 32'(imem_req), 32'h1);
    chk("lit_c1_addr", 32'(imem_addr), 32'h00);
    chk("lit_c1_valid", 32'(valid), 32'h0);
    to_pos();
    at_neg();
    chk("lit_c2_valid", 32'(valid), 32'h1);
    chk("lit_c2_pc", 32'(pc_out), 32'h00);
    chk("lit_c2_instr", 32'(instruction), 32'hA500);
    to_pos();
    at_neg();
    chk("lit_c3_pc", 32'(pc_out), 32'h01);
    chk("lit_c3_instr", 32'(instruction), 32'hA501);
    to_pos();
    run(5);

    // 2: stall until full, then release
    deq_ready = 1'b0;
    run(9);
    at_neg();
    chk("lit_full_count", 32'(count), 32'h4);
    chk("lit_full_req", 32'(imem_req), 32'h0);
    chk("lit_full_pc", 32'(pc_out), 32'h07);
    to_pos();
    deq_ready = 1'b1;
    at_neg();
    chk("lit_rel_pc0", 32'(pc_out), 32'h07);
    to_pos();
    at_neg();
    chk("lit_rel_pc1", 32'(pc_out), 32'h08);
    chk("lit_rel_addr", 32'(imem_addr), 32'h0B);
    to_pos();
    run(6);

    // 3: three stored + one in flight, redirect to 0x40
    deq_ready = 1'b0;
    cycle();
    redirect = 1'b1; redirect_pc = 8'h40;
    at_neg();
    chk("lit_r3_count", 32'(count), 32'h3);
    to_pos();
    redirect = 1'b0; deq_ready = 1'b1;
    at_neg();
    chk("lit_r3_valid", 32'(valid), 32'h0);
    chk("lit_r3_req", 32'(imem_req), 32'h1);
    chk("lit_r3_addr", 32'(imem_addr), 32'h40);
    to_pos();
    at_neg();
    chk("lit_r3_pc", 32'(pc_out), 32'h40);
    chk("lit_r3_instr", 32'(instruction), 32'hA540);
    to_pos();
    run(4);

    // 4: PC wrap past 0xFF
    redirect = 1'b1; redirect_pc = 8'hFE;
    cycle();
    redirect = 1'b0;
    cycle();
    at_neg(); chk("lit_wrap_fe", 32'(pc_out), 32'hFE); to_pos();
    at_neg(); chk("lit_wrap_ff", 32'(pc_out), 32'hFF); to_pos();
    at_neg(); chk("lit_wrap_00", 32'(pc_out), 32'h00); to_pos();
    at_neg(); chk("lit_wrap_01", 32'(pc_out), 32'h01);
    chk("lit_wrap_i01", 32'(instruction), 32'hA501); to_pos();

    // 5: full queue, dequeue and redirect in the same cycle
    deq_ready = 1'b0;
    run(6);
    redirect = 1'b1; redirect_pc = 8'h80; deq_ready = 1'b1;
    at_neg();
    chk("lit_r5_full", 32'(count), 32'h4);
    to_pos();
    redirect = 1'b0;
    at_neg();
    chk("lit_r5_count", 32'(count), 32'h0);
    chk("lit_r5_valid", 32'(valid), 32'h0);
    to_pos();
    at_neg();
    chk("lit_r5_pc", 32'(pc_out), 32'h80);
    to_pos();
    run(3);

    // 6: asynchronous reset pulse between edges
    #1;
    chk("lit_pre_rst_valid", 32'(valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("lit_arst_valid", 32'(valid), 32'h0);
    chk("lit_arst_count", 32'(count), 32'h0);
    chk("lit_arst_req", 32'(imem_req), 32'h0);
    model_reset();
    #1;
    reset = 1'b0;
    at_neg();
    chk("lit_a1_req", 32'(imem_req), 32'h1);
    chk("lit_a1_addr", 32'(imem_addr), 32'h00);
    chk("lit_a1_valid", 32'(valid), 32'h0);
    to_pos();
    at_neg();
    chk("lit_a2_valid", 32'(valid), 32'h1);
    chk("lit_a2_pc", 32'(pc_out), 32'h00);
    to_pos();
    run(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
